// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debounce bank: channel FSM encoding,
// counter widths and a small width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_LOW_PEND  = 2'd1,
    ST_HIGH      = 2'd2,
    ST_HIGH_PEND = 2'd3
  } deb_state_t;

  localparam int STAB_W = 8;
  localparam int HOLD_W = 16;
  localparam int RPT_W  = 16;

  // Accepted level is high while a high level is held or a release is pending.
  function automatic logic is_high(input deb_state_t s);
    return (s == ST_HIGH) || (s == ST_HIGH_PEND);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m_debounce_ch.sv
// One debounce channel: stability FSM on sample ticks plus long-press and
// auto-repeat timing. All pulse outputs are registered one-clk strobes.
module m_debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE = 4,
  parameter int HOLD   = 100,
  parameter int REPEAT = 0
) (
  input  logic clk,
  input  logic res,
  input  logic tick,
  input  logic sw_sync,
  output logic sw_out,
  output logic rise,
  output logic fall,
  output logic long,
  output logic rpt
);

  localparam logic [STAB_W-1:0] STABLE_C = STAB_W'(STABLE);
  localparam logic [HOLD_W-1:0] HOLD_C   = HOLD_W'(HOLD);
  localparam logic [RPT_W-1:0]  REPEAT_C = RPT_W'(REPEAT);

  deb_state_t        state_reg, state_next;
  logic [STAB_W-1:0] stab_reg, stab_next, stab_inc;
  logic [HOLD_W-1:0] hold_reg, hold_next, hold_inc;
  logic [RPT_W-1:0]  rep_reg, rep_next, rep_inc;
  logic              rise_reg, rise_next;
  logic              fall_reg, fall_next;
  logic              long_reg, long_next;
  logic              rpt_reg, rpt_next;

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg <= ST_LOW;
      stab_reg  <= '0;
      hold_reg  <= '0;
      rep_reg   <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      long_reg  <= 1'b0;
      rpt_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      stab_reg  <= stab_next;
      hold_reg  <= hold_next;
      rep_reg   <= rep_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
      long_reg  <= long_next;
      rpt_reg   <= rpt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stab_next  = stab_reg;
    hold_next  = hold_reg;
    rep_next   = rep_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    long_next  = 1'b0;
    rpt_next   = 1'b0;
    stab_inc   = stab_reg + 1'b1;
    hold_inc   = hold_reg + 1'b1;
    rep_inc    = rep_reg + 1'b1;
    if (tick) begin
      unique case (state_reg)
        ST_LOW: if (sw_sync) begin
          if (STABLE == 1) rise_next = 1'b1;
          else begin
            state_next = ST_LOW_PEND;
            stab_next  = STAB_W'(1);
          end
        end
        ST_LOW_PEND:
          if (!sw_sync) begin
            state_next = ST_LOW;
            stab_next  = '0;
          end else if (stab_inc == STABLE_C) rise_next = 1'b1;
          else stab_next = stab_inc;
        ST_HIGH: if (!sw_sync) begin
          if (STABLE == 1) fall_next = 1'b1;
          else begin
            state_next = ST_HIGH_PEND;
            stab_next  = STAB_W'(1);
          end
        end
        ST_HIGH_PEND:
          if (sw_sync) begin
            state_next = ST_HIGH;
            stab_next  = '0;
          end else if (stab_inc == STABLE_C) fall_next = 1'b1;
          else stab_next = stab_inc;
        default: ;
      endcase
      // Hold timing keeps running through a pending release; the release tick itself is silent.
      if (is_high(state_reg) && !fall_next) begin
        if (hold_reg != HOLD_C) begin
          hold_next = hold_inc;
          long_next = (hold_inc == HOLD_C);
        end else if (REPEAT != 0) begin
          if (rep_inc == REPEAT_C) begin
            rpt_next = 1'b1;
            rep_next = '0;
          end else rep_next = rep_inc;
        end
      end
      if (rise_next) begin
        state_next = ST_HIGH;
        stab_next  = '0;
        hold_next  = '0;
        rep_next   = '0;
      end
      if (fall_next) begin
        state_next = ST_LOW;
        stab_next  = '0;
        hold_next  = '0;
        rep_next   = '0;
      end
    end
  end

  always_comb begin
    sw_out = is_high(state_reg);
    rise   = rise_reg;
    fall   = fall_reg;
    long   = long_reg;
    rpt    = rpt_reg;
  end

endmodule

// File: rtl/m_debounce_bank.sv
// Bank of N debounced switches sharing one sample-tick prescaler; each raw
// input is double-flopped before reaching its channel FSM.
module m_debounce_bank
  import debounce_pkg::*;
#(
  parameter int N        = 4,
  parameter int TICK_DIV = 50000,
  parameter int STABLE   = 4,
  parameter int HOLD     = 100,
  parameter int REPEAT   = 0
) (
  input  logic         clk,
  input  logic         res,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] sw_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] long,
  output logic [N-1:0] rpt
);

  localparam int               DIV_W    = cnt_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [N-1:0]     sync1_reg, sync2_reg;
  logic [DIV_W-1:0] div_reg;
  logic             tick;

  assign tick = (div_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (res) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      div_reg   <= '0;
    end else begin
      sync1_reg <= sw_in;
      sync2_reg <= sync1_reg;
      div_reg   <= tick ? '0 : div_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      m_debounce_ch #(
        .STABLE (STABLE),
        .HOLD   (HOLD),
        .REPEAT (REPEAT)
      ) u_ch (
        .clk     (clk),
        .res     (res),
        .tick    (tick),
        .sw_sync (sync2_reg[gi]),
        .sw_out  (sw_out[gi]),
        .rise    (rise[gi]),
        .fall    (fall[gi]),
        .long    (long[gi]),
        .rpt     (rpt[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_m_debounce_bank.sv
// Directed bench for m_debounce_bank: expected pulse events are scheduled from
// tick arithmetic when a press is driven and compared edge by edge.
module tb_m_debounce_bank;

  localparam int N        = 2;
  localparam int TICK_DIV = 4;
  localparam int STABLE   = 3;
  localparam int HOLD     = 5;
  localparam int REPEAT   = 2;
  localparam int BIG      = 1 << 28;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic [N-1:0] sw_in = '0;
  logic [N-1:0] sw_out, rise, fall, long_p, rpt;
  logic [N-1:0] sw_out0, rise0, fall0, long0, rpt0;

  always #5 clk = ~clk;

  m_debounce_bank #(
    .N (N), .TICK_DIV (TICK_DIV), .STABLE (STABLE), .HOLD (HOLD), .REPEAT (REPEAT)
  ) u_dut (
    .clk (clk), .res (res), .sw_in (sw_in), .sw_out (sw_out),
    .rise (rise), .fall (fall), .long (long_p), .rpt (rpt)
  );

  m_debounce_bank #(
    .N (N), .TICK_DIV (TICK_DIV), .STABLE (STABLE), .HOLD (HOLD), .REPEAT (0)
  ) u_dut_norpt (
    .clk (clk), .res (res), .sw_in (sw_in), .sw_out (sw_out0),
    .rise (rise0), .fall (fall0), .long (long0), .rpt (rpt0)
  );

  typedef enum int {EV_RISE, EV_FALL, EV_LONG, EV_RPT} ev_kind_t;
  typedef struct {
    int       at;
    int       ch;
    ev_kind_t kind;
  } ev_t;

  ev_t          exp_q[$];
  int           e = -1;
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] exp_lvl = '0;

  // First tick edge at or after edge x (tick edges are x % TICK_DIV == TICK_DIV-1).
  function automatic int next_tick(input int x);
    return x + (TICK_DIV - 1 - (x % TICK_DIV));
  endfunction

  task automatic push_ev(input int at, input int ch, input ev_kind_t k, input int cut);
    ev_t ev;
    if (at < cut) begin
      ev.at = at; ev.ch = ch; ev.kind = k;
      exp_q.push_back(ev);
    end
  endtask

  // Input driven high after edge d_on and low after edge d_off; FSM sees it 3 edges later.
  task automatic push_press(input int ch, input int d_on, input int d_off, input int cut);
    int a, f, t;
    a = next_tick(d_on + 3) + (STABLE - 1) * TICK_DIV;
    f = next_tick(d_off + 3) + (STABLE - 1) * TICK_DIV;
    push_ev(a, ch, EV_RISE, cut);
    t = a + HOLD * TICK_DIV;
    if (t < f) begin
      push_ev(t, ch, EV_LONG, cut);
      if (REPEAT != 0) begin
        t = t + REPEAT * TICK_DIV;
        while (t < f && t < cut) begin
          push_ev(t, ch, EV_RPT, cut);
          t = t + REPEAT * TICK_DIV;
        end
      end
    end
    push_ev(f, ch, EV_FALL, cut);
  endtask

  task automatic cmp(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, expv);
    end
  endtask

  task automatic check_edge(input int at);
    logic [N-1:0] er, ef, el, ep;
    er = '0; ef = '0; el = '0; ep = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at == at) begin
        case (exp_q[i].kind)
          EV_RISE: er[exp_q[i].ch] = 1'b1;
          EV_FALL: ef[exp_q[i].ch] = 1'b1;
          EV_LONG: el[exp_q[i].ch] = 1'b1;
          default: ep[exp_q[i].ch] = 1'b1;
        endcase
        exp_q.delete(i);
      end
    end
    exp_lvl = (exp_lvl | er) & ~ef;
    cmp("rise", rise, er);
    cmp("fall", fall, ef);
    cmp("long", long_p, el);
    cmp("rpt", rpt, ep);
    cmp("sw_out", sw_out, exp_lvl);
    cmp("rise_norpt", rise0, er);
    cmp("fall_norpt", fall0, ef);
    cmp("long_norpt", long0, el);
    cmp("rpt_norpt", rpt0, '0);
    cmp("sw_out_norpt", sw_out0, exp_lvl);
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    @(negedge clk);
    check_edge(e);
  endtask

  task automatic run_to(input int target);
    while (e < target) step();
  endtask

  // One clock with res high: nothing pending survives and every output must be 0.
  task automatic reset_cycle();
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    exp_lvl = '0;
    check_edge(-BIG);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog edge=%0d observed=timeout expected=finish", e);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, a;
    repeat (3) reset_cycle();
    res = 1'b0;
    e   = -1;
    run_to(10);

    // Clean press and release on channel 0; channel 1 stays quiet.
    d = e;
    push_press(0, d, d + 40, BIG);
    sw_in[0] = 1'b1;
    run_to(d + 40);
    sw_in[0] = 1'b0;
    run_to(d + 70);

    // Bounce: level changes every 2 ticks for 20 ticks, never accepted.
    for (int k = 0; k < 10; k++) begin
      sw_in[0] = ~sw_in[0];
      repeat (2 * TICK_DIV) step();
    end
    run_to(e + 20);

    // Channel 1 long press: long, repeats, then release with no later repeat.
    d = e;
    a = next_tick(d + 3) + (STABLE - 1) * TICK_DIV;
    push_press(1, d, a + 36, BIG);
    sw_in[1] = 1'b1;
    run_to(a + 36);
    sw_in[1] = 1'b0;
    run_to(a + 80);

    // Both channels pressed together.
    d = e;
    push_press(0, d, d + 30, BIG);
    push_press(1, d, d + 30, BIG);
    sw_in = 2'b11;
    run_to(d + 30);
    sw_in = 2'b00;
    run_to(d + 60);

    // Reset while channel 0 is accepted high; held input is re-accepted afterwards.
    d = e;
    a = next_tick(d + 3) + (STABLE - 1) * TICK_DIV;
    push_press(0, d, BIG, a + 3);
    sw_in[0] = 1'b1;
    run_to(a + 2);
    res = 1'b1;
    reset_cycle();
    res = 1'b0;
    e   = -1;
    push_press(0, -1, 40, BIG);
    run_to(40);
    sw_in[0] = 1'b0;
    run_to(70);

    // Hold over 20 ticks: one long on both builds, repeats only on the repeating one.
    d = e;
    a = next_tick(d + 3) + (STABLE - 1) * TICK_DIV;
    push_press(0, d, a + 90, BIG);
    sw_in[0] = 1'b1;
    run_to(a + 90);
    sw_in[0] = 1'b0;
    run_to(a + 130);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL pending_events observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_debounce_bank.md
M_DEBOUNCE_BANK -- requirements
Module: m_debounce_bank

Interface
REQ-001 Parameter N, default 4, number of independent switch channels (1..32).
REQ-002 Parameter TICK_DIV, default 50000, clocks per sample tick (>=2).
REQ-003 Parameter STABLE, default 4, consecutive ticks of a new level required to accept it (1..255).
REQ-004 Parameter HOLD, default 100, ticks of accepted-high level before the long-press pulse (1..65535).
REQ-005 Parameter REPEAT, default 0, ticks between auto-repeat pulses after long press; 0 disables repeat.
REQ-006 clk  in  1  system clock; all logic on posedge clk.
REQ-007 res  in  1  reset, synchronous, active-high.
REQ-008 sw_in  in  N  raw asynchronous switch inputs.
REQ-009 sw_out  out  N  debounced level per channel.
REQ-010 rise  out  N  one-clk pulse on accepted 0->1.
REQ-011 fall  out  N  one-clk pulse on accepted 1->0.
REQ-012 long  out  N  one-clk pulse when high held HOLD ticks.
REQ-013 rpt  out  N  one-clk auto-repeat pulse.

Function
REQ-014 Each sw_in bit SHALL pass a two-flop synchronizer; sw_sync lags sw_in by 2 clk.
REQ-015 One shared prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is high for exactly the one clk where count==TICK_DIV-1.
REQ-016 Per-channel FSM states: LOW, LOW_PEND, HIGH, HIGH_PEND; evaluated only on tick clocks, held otherwise.
REQ-017 LOW: sw_sync=1 on tick -> LOW_PEND, stab_cnt=1 (if STABLE==1, go directly to HIGH).
REQ-018 LOW_PEND on tick: sw_sync=0 -> LOW, stab_cnt=0; sw_sync=1 -> stab_cnt+1; when stab_cnt+1==STABLE -> HIGH, stab_cnt=0.
REQ-019 HIGH/HIGH_PEND SHALL mirror REQ-017/018 with levels inverted, returning to LOW on acceptance.
REQ-020 sw_out SHALL be 1 exactly in HIGH and HIGH_PEND; sw_in changes between ticks SHALL have no effect.
REQ-021 rise/fall SHALL be high for the single clk in which sw_out first shows the new level.
REQ-022 hold_cnt (16 bit) SHALL clear on entry to HIGH, increment on each tick while sw_out=1, saturate at HOLD.
REQ-023 long SHALL pulse on the clk hold_cnt reaches HOLD; exactly once per press.
REQ-024 If REPEAT!=0, rpt SHALL pulse every REPEAT ticks after long while sw_out=1 (first rpt REPEAT ticks after long); never when REPEAT==0.
REQ-025 Release (accepted fall) SHALL clear hold_cnt and repeat counter; no long/rpt on the fall clk.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels all produce their pulses in the same clk.
REQ-027 Minimum accept latency: 2 clk sync + STABLE ticks; input toggling every tick SHALL never change sw_out.

Reset
REQ-028 While res=1 on a posedge: synchronizers, prescaler, all counters cleared; all FSMs to LOW; sw_out, rise, fall, long, rpt all 0.
REQ-029 Reset mid-press SHALL drop sw_out to 0 without generating fall; a held switch is re-accepted after STABLE ticks, giving a fresh rise.

Structure
REQ-030 State encoding and counter widths SHALL live in shared package debounce_pkg.
REQ-031 Per-channel FSM plus counters SHALL be sub-module m_debounce_ch, instantiated N times by generate; prescaler and synchronizers in the top.

Verification (N=2, TICK_DIV=4, STABLE=3, HOLD=5, REPEAT=2)
REQ-032 sw_in[0] 0->1 held -> sw_out[0]=1 and rise[0] one clk after 3rd tick post-sync; channel 1 silent.
REQ-033 sw_in[0] toggles every 2 ticks for 20 ticks -> sw_out[0], rise, fall stay 0.
REQ-034 Hold channel 1 high 12 ticks after acceptance -> long at tick 5, rpt at ticks 7, 9, 11; release -> fall, no further rpt.
REQ-035 Both channels rise in same clk -> rise=2'b11 for one clk.
REQ-036 res asserted one clk during HIGH -> all outputs 0 next clk, no fall; held input -> rise 3 ticks after release of res.
REQ-037 REPEAT=0 build, hold 20 ticks -> exactly one long, rpt never asserted.
